// File: rtl/ps2_host_tx_pkg.sv
// Shared types, constants and helpers for the PS/2 host transmitter.
// Command bytes are shared with the keyboard-side logic.
package ps2_host_tx_pkg;

    localparam int CNT_W = 19;
    localparam int BIT_W = 4;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAITREL
    } state_t;

    // {stop, odd parity, data}; shifted out LSB first
    function automatic logic [9:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request handshake and status between a client and the
// PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, error
    );

endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 pin conditioner: 2-FF synchroniser, FILTER_LEN-sample
// deglitch and a registered falling-edge pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [1:0]            sync;
    logic [FILTER_LEN-2:0] hist;
    logic [FILTER_LEN-1:0] win;

    assign win = {hist, sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            hist <= win[FILTER_LEN-2:0];
            fall <= level & ~|win;
            if (&win)
                level <= 1'b1;
            else if (~|win)
                level <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain
// clock/data enables; reports done on ACK, error otherwise.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam logic [CNT_W-1:0] INH_LAST =
        CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_n;
    logic [9:0]       shift, shift_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [BIT_W-1:0] bitcnt, bitcnt_n;
    logic             clk_oe_n, data_oe_n;
    logic             done_q, done_n;
    logic             error_q, error_n;
    logic             clk_lvl, clk_fall, data_lvl;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ps2_data_in),
        .level (data_lvl),
        .fall  ()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shift       <= '0;
            cnt         <= '0;
            bitcnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            cnt         <= cnt_n;
            bitcnt      <= bitcnt_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done_q      <= done_n;
            error_q     <= error_n;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        error_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    shift_n  = make_frame(bus.tx_data);
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    clk_oe_n = 1'b1;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_n = sat_inc(cnt);
                if (cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_n = 1'b0;
                cnt_n    = '0;
                state_n  = S_SHIFT;
            end
            S_SHIFT: begin
                if (clk_fall) begin
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b0, shift[9:1]};
                    bitcnt_n  = bitcnt + 1'b1;
                    if (bitcnt == BIT_W'(9))
                        state_n = S_ACK;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (data_lvl) begin
                        error_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_WAITREL;
                    end
                end
            end
            S_WAITREL: begin
                if (clk_lvl && data_lvl) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // frame watchdog; also catches an absent device
        if (state == S_SHIFT || state == S_ACK ||
            state == S_WAITREL) begin
            cnt_n = sat_inc(cnt);
            if (cnt == TMO_LAST) begin
                done_n  = 1'b0;
                error_n = 1'b1;
                state_n = S_IDLE;
            end
        end
        if (state != S_IDLE && state_n == S_IDLE) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
        end
    end

    assign bus.tx_ready = (state == S_IDLE);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;
    assign bus.error    = error_q;

endmodule
